// File: rtl/irq_ctrl_if.sv
// Register port and interrupt outputs of irq_ctrl, bundled.
// The slave side is the controller. The master side is software or a bench.
interface irq_ctrl_if #(
  parameter int N_IRQ = 8
) ();
  logic [N_IRQ-1:0] i_irqIn;
  logic             i_we;
  logic [3:0]       i_a;
  logic [31:0]      i_wd;
  logic [31:0]      o_rd;
  logic             o_interrupt;
  logic [4:0]       o_intId;
  logic             o_intValid;

  modport slave (
    input  i_irqIn, i_we, i_a, i_wd,
    output o_rd, o_interrupt, o_intId, o_intValid
  );

  modport master (
    output i_irqIn, i_we, i_a, i_wd,
    input  o_rd, o_interrupt, o_intId, o_intValid
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: parametrised interrupt controller.
// Each external line passes through a synchroniser and an optional debounce
// filter, then through polarity. Edge or level capture sets the pending bits,
// and the mask selects which pending bits raise the request. The registered
// request and the lowest enabled source ID go to cp0.
module irq_ctrl #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 0
) (
  input logic       clk,
  input logic       rst,
  irq_ctrl_if.slave bus
);

  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] w_s;
  logic [N_IRQ-1:0] w_filt;
  logic [N_IRQ-1:0] w_act;
  logic [N_IRQ-1:0] w_w1c;
  logic [N_IRQ-1:0] w_enabled;
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] r_mode;
  logic [N_IRQ-1:0] r_pol;
  logic             r_interrupt;
  logic [4:0]       r_intId;
  logic [4:0]       w_id;
  logic             w_unusedWd;

  // Write-data bits above the implemented lines are ignored.
  assign w_unusedWd = &{1'b0, bus.i_wd[31:N_IRQ]};

  // Synchroniser chain: raw lines are shifted through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= bus.i_irqIn;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  generate
    if (DEB_CYCLES == 0) begin : g_noDeb
      assign w_filt = w_s;
    end else begin : g_deb
      localparam int CW = $clog2(DEB_CYCLES + 1);
      for (genvar i = 0; i < N_IRQ; i++) begin : g_line
        logic [CW-1:0] r_cnt;
        logic          r_filtBit;
        // Debounce: accept a change only after DEB_CYCLES consecutive mismatching cycles.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            r_cnt     <= '0;
            r_filtBit <= 1'b0;
          end else if (w_s[i] == r_filtBit) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
            r_filtBit <= w_s[i];
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        assign w_filt[i] = r_filtBit;
      end
    end
  endgenerate

  assign w_act     = w_filt ^ r_pol;
  assign w_w1c     = (bus.i_we && bus.i_a == 4'd0) ? bus.i_wd[N_IRQ-1:0] : '0;
  assign w_enabled = r_pending & r_mask;

  // Pending capture: in edge mode a new rising edge beats a same-cycle W1C; in level mode pending follows the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= w_act;
      r_pending <= (r_mode & ((w_act & ~r_prev) | (r_pending & ~w_w1c)))
                 | (~r_mode & w_act);
    end
  end

  // Configuration registers written from the word port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_mode <= '0;
      r_pol  <= '0;
    end else if (bus.i_we) begin
      case (bus.i_a)
        4'd1:    r_mask <= bus.i_wd[N_IRQ-1:0];
        4'd2:    r_mode <= bus.i_wd[N_IRQ-1:0];
        4'd3:    r_pol  <= bus.i_wd[N_IRQ-1:0];
        default: ;
      endcase
    end
  end

  // Priority encoder: lowest enabled pending line wins, 0 when none.
  always_comb begin
    w_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_enabled[i]) w_id = 5'(i);
    end
  end

  // Registered request and source ID toward cp0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_interrupt <= 1'b0;
      r_intId     <= '0;
    end else begin
      r_interrupt <= |w_enabled;
      r_intId     <= w_id;
    end
  end

  // Read mux: combinational from the word index, no side effects.
  always_comb begin
    bus.o_rd = '0;
    case (bus.i_a)
      4'd0:    bus.o_rd[N_IRQ-1:0] = r_pending;
      4'd1:    bus.o_rd[N_IRQ-1:0] = r_mask;
      4'd2:    bus.o_rd[N_IRQ-1:0] = r_mode;
      4'd3:    bus.o_rd[N_IRQ-1:0] = r_pol;
      4'd4:    bus.o_rd = {r_interrupt, 26'b0, r_intId};
      4'd5:    bus.o_rd[N_IRQ-1:0] = w_filt;
      default: ;
    endcase
  end

  assign bus.o_interrupt = r_interrupt;
  assign bus.o_intValid  = r_interrupt;
  assign bus.o_intId     = r_intId;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Two instances share one stimulus:
// dut0 has no debounce, and dut4 debounces over 4 cycles.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irqIn;
  logic        we;
  logic [3:0]  a;
  logic [31:0] wd;
  logic [31:0] rd0;
  logic [31:0] rd4;
  int          checkCount = 0;
  int          errorCount = 0;

  irq_ctrl_if #(.N_IRQ(8)) bus0 ();
  irq_ctrl_if #(.N_IRQ(8)) bus4 ();

  assign bus0.i_irqIn = irqIn;
  assign bus0.i_we    = we;
  assign bus0.i_a     = a;
  assign bus0.i_wd    = wd;
  assign bus4.i_irqIn = irqIn;
  assign bus4.i_we    = we;
  assign bus4.i_a     = a;
  assign bus4.i_wd    = wd;

  irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2), .DEB_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  irq_ctrl #(.N_IRQ(8), .SYNC_STAGES(2), .DEB_CYCLES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and settle 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle register write. It takes effect on the edge inside this task.
  task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data);
    we = 1'b1;
    a  = addr;
    wd = data;
    tick(1);
    we = 1'b0;
    wd = '0;
  endtask

  // Combinational register read from both instances.
  task automatic readReg(input logic [3:0] addr);
    a = addr;
    #1;
    rd0 = bus0.o_rd;
    rd4 = bus4.o_rd;
  endtask

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    rst = 1'b1; irqIn = '0; we = 1'b0; a = '0; wd = '0;
    #12;
    checkOutput("rst int0", 32'(bus0.o_interrupt), 32'h0);
    checkOutput("rst valid4", 32'(bus4.o_intValid), 32'h0);
    readReg(4'd4);
    checkOutput("rst status0", rd0, 32'h0);
    checkOutput("rst status4", rd4, 32'h0);
    rst = 1'b0;
    tick(1);

    // Edge mode, line 0 only: a one-cycle pulse latches pending.
    applyStimulus(4'd2, 32'hFF);
    applyStimulus(4'd1, 32'h01);
    irqIn = 8'h01;
    tick(1);
    irqIn = 8'h00;
    checkOutput("edge int e1", 32'(bus0.o_interrupt), 32'h0);
    tick(2);
    readReg(4'd0);
    checkOutput("edge pend e3", rd0, 32'h01);
    checkOutput("edge int e3", 32'(bus0.o_interrupt), 32'h0);
    tick(1);
    checkOutput("edge int e4", 32'(bus0.o_interrupt), 32'h1);
    checkOutput("edge valid e4", 32'(bus0.o_intValid), 32'h1);
    checkOutput("edge id e4", 32'(bus0.o_intId), 32'h0);
    tick(5);
    readReg(4'd0);
    checkOutput("edge pend held", rd0, 32'h01);
    applyStimulus(4'd0, 32'h01);
    readReg(4'd0);
    checkOutput("w1c pend", rd0, 32'h00);
    checkOutput("w1c int same", 32'(bus0.o_interrupt), 32'h1);
    tick(1);
    checkOutput("w1c int next", 32'(bus0.o_interrupt), 32'h0);

    // Level mode on line 3: pending follows the line, W1C ignored.
    applyStimulus(4'd2, 32'h00);
    applyStimulus(4'd1, 32'hFF);
    irqIn = 8'h08;
    tick(4);
    checkOutput("lvl int", 32'(bus0.o_interrupt), 32'h1);
    readReg(4'd4);
    checkOutput("lvl status", rd0, 32'h80000003);
    applyStimulus(4'd0, 32'h08);
    readReg(4'd0);
    checkOutput("lvl w1c noop", rd0, 32'h08);
    irqIn = 8'h00;
    tick(2);
    readReg(4'd0);
    checkOutput("lvl pend e2", rd0, 32'h08);
    tick(1);
    readReg(4'd0);
    checkOutput("lvl pend e3", rd0, 32'h00);
    checkOutput("lvl int e3", 32'(bus0.o_interrupt), 32'h1);
    tick(1);
    checkOutput("lvl int e4", 32'(bus0.o_interrupt), 32'h0);

    // Priority: lines 5 and 2 pending, then line 2 masked off.
    applyStimulus(4'd2, 32'hFF);
    irqIn = 8'h24;
    tick(1);
    irqIn = 8'h00;
    tick(3);
    checkOutput("prio int", 32'(bus0.o_interrupt), 32'h1);
    readReg(4'd4);
    checkOutput("prio status", rd0, 32'h80000002);
    applyStimulus(4'd1, 32'hFB);
    readReg(4'd4);
    checkOutput("prio mask same", rd0, 32'h80000002);
    tick(1);
    readReg(4'd4);
    checkOutput("prio mask next", rd0, 32'h80000005);
    applyStimulus(4'd0, 32'hFF);
    tick(1);
    checkOutput("prio clr int", 32'(bus0.o_interrupt), 32'h0);
    applyStimulus(4'd1, 32'hFF);

    // Polarity on line 1: the POL write itself makes an edge; idle high stays quiet.
    applyStimulus(4'd3, 32'h02);
    irqIn = 8'h02;
    tick(1);
    readReg(4'd0);
    checkOutput("pol write edge", rd0, 32'h02);
    tick(5);
    applyStimulus(4'd0, 32'h02);
    tick(5);
    readReg(4'd0);
    checkOutput("pol idle high", rd0, 32'h00);
    irqIn = 8'h00;
    tick(2);
    applyStimulus(4'd0, 32'h02);
    readReg(4'd0);
    checkOutput("pol set wins", rd0, 32'h02);
    applyStimulus(4'd0, 32'h02);
    readReg(4'd0);
    checkOutput("pol w1c", rd0, 32'h00);
    applyStimulus(4'd3, 32'h00);

    // Debounce: a 3-cycle glitch is rejected by dut4 but caught by dut0.
    tick(10);
    applyStimulus(4'd0, 32'hFF);
    tick(2);
    readReg(4'd0);
    checkOutput("deb idle pend4", rd4, 32'h00);
    irqIn = 8'h04;
    tick(3);
    irqIn = 8'h00;
    tick(10);
    readReg(4'd5);
    checkOutput("glitch raw4", rd4, 32'h00);
    readReg(4'd0);
    checkOutput("glitch pend4", rd4, 32'h00);
    checkOutput("glitch pend0", rd0, 32'h04);

    // Debounce: a long pulse is accepted after SYNC+4 edges, pending at +1.
    irqIn = 8'h04;
    tick(6);
    readReg(4'd0);
    checkOutput("deb pend4 e6", rd4, 32'h00);
    readReg(4'd5);
    checkOutput("deb raw4 e6", rd4, 32'h04);
    tick(1);
    readReg(4'd0);
    checkOutput("deb pend4 e7", rd4, 32'h04);
    checkOutput("deb int4 e7", 32'(bus4.o_interrupt), 32'h0);
    tick(1);
    checkOutput("deb int4 e8", 32'(bus4.o_interrupt), 32'h1);
    readReg(4'd4);
    checkOutput("deb status4", rd4, 32'h80000002);

    // Async reset while line 6 is mid-debounce and interrupts are pending.
    irqIn = 8'h44;
    tick(3);
    checkOutput("pre-rst int0", 32'(bus0.o_interrupt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst int0", 32'(bus0.o_interrupt), 32'h0);
    checkOutput("arst int4", 32'(bus4.o_interrupt), 32'h0);
    checkOutput("arst valid0", 32'(bus0.o_intValid), 32'h0);
    checkOutput("arst id0", 32'(bus0.o_intId), 32'h0);
    readReg(4'd0);
    checkOutput("arst pend0", rd0, 32'h00);
    checkOutput("arst pend4", rd4, 32'h00);
    irqIn = 8'h00;
    tick(2);
    #2;
    rst = 1'b0;
    tick(10);
    checkOutput("post-rst int0", 32'(bus0.o_interrupt), 32'h0);
    checkOutput("post-rst int4", 32'(bus4.o_interrupt), 32'h0);
    readReg(4'd0);
    checkOutput("post-rst pend0", rd0, 32'h00);
    checkOutput("post-rst pend4", rd4, 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
